// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: PS/2 scancodes, joystick bit
// positions, key-state slot assignments and the coin FSM state type.
package arcade_input_pkg;

  // PS/2 set-2 scancodes (low byte; the extended flag is tracked separately)
  localparam logic [7:0] SC_P1_UP     = 8'h75;  // with E0
  localparam logic [7:0] SC_P1_DOWN   = 8'h72;  // with E0
  localparam logic [7:0] SC_P1_LEFT   = 8'h6B;  // with E0
  localparam logic [7:0] SC_P1_RIGHT  = 8'h74;  // with E0
  localparam logic [7:0] SC_P1_FIRE_A = 8'h29;  // space
  localparam logic [7:0] SC_P1_FIRE_B = 8'h14;  // ctrl (left or right)
  localparam logic [7:0] SC_P2_UP     = 8'h1D;
  localparam logic [7:0] SC_P2_DOWN   = 8'h1B;
  localparam logic [7:0] SC_P2_LEFT   = 8'h1C;
  localparam logic [7:0] SC_P2_RIGHT  = 8'h23;
  localparam logic [7:0] SC_P2_FIRE   = 8'h12;
  localparam logic [7:0] SC_START1_A  = 8'h16;
  localparam logic [7:0] SC_START1_B  = 8'h05;
  localparam logic [7:0] SC_START2_A  = 8'h1E;
  localparam logic [7:0] SC_START2_B  = 8'h06;
  localparam logic [7:0] SC_COIN_A    = 8'h2E;
  localparam logic [7:0] SC_COIN_B    = 8'h36;

  // Joystick word bit positions (same map for both sticks)
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  // One state bit per physical key, so aliased keys OR together cleanly
  localparam int K_P1_UP     = 0;
  localparam int K_P1_DOWN   = 1;
  localparam int K_P1_LEFT   = 2;
  localparam int K_P1_RIGHT  = 3;
  localparam int K_P1_FIRE_A = 4;
  localparam int K_P1_FIRE_B = 5;
  localparam int K_P2_UP     = 6;
  localparam int K_P2_DOWN   = 7;
  localparam int K_P2_LEFT   = 8;
  localparam int K_P2_RIGHT  = 9;
  localparam int K_P2_FIRE   = 10;
  localparam int K_START1_A  = 11;
  localparam int K_START1_B  = 12;
  localparam int K_START2_A  = 13;
  localparam int K_START2_B  = 14;
  localparam int K_COIN_A    = 15;
  localparam int K_COIN_B    = 16;
  localparam int NUM_KEYS    = 17;

  // Match table indexed by key slot: scancode, required E0 flag, E0 ignored
  localparam logic [7:0] KEY_CODE [NUM_KEYS] = '{
    SC_P1_UP, SC_P1_DOWN, SC_P1_LEFT, SC_P1_RIGHT, SC_P1_FIRE_A, SC_P1_FIRE_B,
    SC_P2_UP, SC_P2_DOWN, SC_P2_LEFT, SC_P2_RIGHT, SC_P2_FIRE,
    SC_START1_A, SC_START1_B, SC_START2_A, SC_START2_B, SC_COIN_A, SC_COIN_B
  };
  localparam logic KEY_EXT [NUM_KEYS] = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0
  };
  localparam logic KEY_EXT_ANY [NUM_KEYS] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0
  };

  typedef enum logic [1:0] {IDLE, PULSE, LOCK} coin_state_t;

endpackage

// File: rtl/coin_pulser.sv
// Coin pulse shaper: turns a one-cycle request into a fixed-width high pulse
// followed by a fixed low lockout. Requests outside IDLE are dropped.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYC = 2400000,
  parameter int unsigned COIN_LOCK_CYC  = 2400000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req_edge,
  output logic pulse
);

  localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE_CYC - 1);
  localparam logic [23:0] LOCK_LOAD  = 24'(COIN_LOCK_CYC - 1);

  coin_state_t state_q;
  logic [23:0] cnt_q;

  // FSM with registered pulse output; counter runs down to 0 in PULSE/LOCK
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 24'd0;
      pulse   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pulse <= 1'b0;
          if (req_edge) begin
            state_q <= PULSE;
            cnt_q   <= PULSE_LOAD;
            pulse   <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == 24'd0) begin
            state_q <= LOCK;
            cnt_q   <= LOCK_LOAD;
            pulse   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 24'd1;
            pulse <= 1'b1;
          end
        end
        LOCK: begin
          pulse <= 1'b0;
          if (cnt_q == 24'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 24'd0;
          pulse   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keyboard events and two joysticks into arcade player controls,
// start buttons and a shaped coin pulse.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYC = 2400000,
  parameter int unsigned COIN_LOCK_CYC  = 2400000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        auto_coin,
  output logic [4:0]  p1,
  output logic [4:0]  p2,
  output logic        start1,
  output logic        start2,
  output logic        coin1
);

  logic                toggle_q;
  logic                key_evt;
  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] key_d;
  logic [4:0]          p1_d;
  logic [4:0]          p2_d;
  logic                start1_d;
  logic                start2_d;
  logic                coin_raw;
  logic                coin_raw_q;
  logic                req_edge;
  logic                unused_joy_hi;

  // Upper joystick bits carry no arcade function here
  assign unused_joy_hi = ^{joystick_0[15:8], joystick_1[15:8]};

  // A new PS/2 event is signalled by the toggle bit changing
  assign key_evt = ps2_key[10] ^ toggle_q;

  // Per-slot scancode match; fire keys accept either E0 prefix state
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
    assign key_hit[gi] = (ps2_key[7:0] == KEY_CODE[gi]) &&
                         (KEY_EXT_ANY[gi] || (ps2_key[8] == KEY_EXT[gi]));
  end

  // Load the pressed flag into every matching slot on an event
  always_comb begin
    key_d = key_q;
    if (key_evt) begin
      key_d = (key_q & ~key_hit) | (key_hit & {NUM_KEYS{ps2_key[9]}});
    end
  end

  // Next-state control bits: key state OR joystick, {fire,up,down,left,right}
  always_comb begin
    p1_d = {key_q[K_P1_FIRE_A] | key_q[K_P1_FIRE_B],
            key_q[K_P1_UP], key_q[K_P1_DOWN], key_q[K_P1_LEFT], key_q[K_P1_RIGHT]}
           | joystick_0[JOY_FIRE:JOY_RIGHT];
    p2_d = {key_q[K_P2_FIRE], key_q[K_P2_UP], key_q[K_P2_DOWN],
            key_q[K_P2_LEFT], key_q[K_P2_RIGHT]}
           | joystick_1[JOY_FIRE:JOY_RIGHT];
    start1_d = key_q[K_START1_A] | key_q[K_START1_B] |
               joystick_0[JOY_START1] | joystick_1[JOY_START1];
    start2_d = key_q[K_START2_A] | key_q[K_START2_B] |
               joystick_0[JOY_START2] | joystick_1[JOY_START2];
    coin_raw = key_q[K_COIN_A] | key_q[K_COIN_B] |
               joystick_0[JOY_COIN] | joystick_1[JOY_COIN] |
               (auto_coin & (start1_d | start2_d));
  end

  // One request per rising edge of coin_raw, however long it stays high
  assign req_edge = coin_raw & ~coin_raw_q;

  // Key state, output registers and edge-detect history; the history
  // registers track their inputs during reset so nothing fires on release
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q   <= ps2_key[10];
      coin_raw_q <= coin_raw;
      key_q      <= '0;
      p1         <= 5'd0;
      p2         <= 5'd0;
      start1     <= 1'b0;
      start2     <= 1'b0;
    end else begin
      toggle_q   <= ps2_key[10];
      coin_raw_q <= coin_raw;
      key_q      <= key_d;
      p1         <= p1_d;
      p2         <= p2_d;
      start1     <= start1_d;
      start2     <= start2_d;
    end
  end

  coin_pulser #(
    .COIN_PULSE_CYC (COIN_PULSE_CYC),
    .COIN_LOCK_CYC  (COIN_LOCK_CYC)
  ) u_coin_pulser (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .req_edge (req_edge),
    .pulse    (coin1)
  );

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: table of key/joystick vectors plus
// hand-written coin, auto-coin and reset sequences.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        auto_coin;
  logic [4:0]  p1;
  logic [4:0]  p2;
  logic        start1;
  logic        start2;
  logic        coin1;

  int checks   = 0;
  int failures = 0;

  arcade_input_mapper #(
    .COIN_PULSE_CYC (8),
    .COIN_LOCK_CYC  (4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .auto_coin  (auto_coin),
    .p1         (p1),
    .p2         (p2),
    .start1     (start1),
    .start2     (start2),
    .coin1      (coin1)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        is_key;
    logic        pressed;
    logic        ext;
    logic [7:0]  code;
    logic [15:0] joy0;
    logic [15:0] joy1;
    logic [4:0]  ep1;
    logic [4:0]  ep2;
    logic        es1;
    logic        es2;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t kv(input logic pr, input logic ex, input logic [7:0] cd,
                              input logic [4:0] e1, input logic [4:0] e2,
                              input logic s1, input logic s2);
    vec_t v;
    v.is_key = 1'b1; v.pressed = pr; v.ext = ex; v.code = cd;
    v.joy0 = 16'h0; v.joy1 = 16'h0;
    v.ep1 = e1; v.ep2 = e2; v.es1 = s1; v.es2 = s2;
    return v;
  endfunction

  function automatic vec_t jv(input logic [15:0] j0, input logic [15:0] j1,
                              input logic [4:0] e1, input logic [4:0] e2,
                              input logic s1, input logic s2);
    vec_t v;
    v.is_key = 1'b0; v.pressed = 1'b0; v.ext = 1'b0; v.code = 8'h00;
    v.joy0 = j0; v.joy1 = j1;
    v.ep1 = e1; v.ep2 = e2; v.es1 = s1; v.es2 = s2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic tgl;
  logic [11:0] prev_exp;
  logic [11:0] new_exp;
  int highs;
  int rises;
  logic prev_c;
  int n;

  initial begin
    // Table: key state accumulates from row to row
    vecs[0]  = kv(1'b1, 1'b1, 8'h74, 5'b00001, 5'b00000, 1'b0, 1'b0);
    vecs[1]  = kv(1'b0, 1'b1, 8'h74, 5'b00000, 5'b00000, 1'b0, 1'b0);
    vecs[2]  = kv(1'b1, 1'b0, 8'h74, 5'b00000, 5'b00000, 1'b0, 1'b0);
    vecs[3]  = kv(1'b1, 1'b0, 8'h29, 5'b10000, 5'b00000, 1'b0, 1'b0);
    vecs[4]  = kv(1'b1, 1'b0, 8'h14, 5'b10000, 5'b00000, 1'b0, 1'b0);
    vecs[5]  = kv(1'b0, 1'b0, 8'h29, 5'b10000, 5'b00000, 1'b0, 1'b0);
    vecs[6]  = kv(1'b0, 1'b0, 8'h14, 5'b00000, 5'b00000, 1'b0, 1'b0);
    vecs[7]  = kv(1'b1, 1'b1, 8'h6B, 5'b00010, 5'b00000, 1'b0, 1'b0);
    vecs[8]  = kv(1'b1, 1'b0, 8'h1D, 5'b00010, 5'b01000, 1'b0, 1'b0);
    vecs[9]  = jv(16'h0005, 16'h0000, 5'b00111, 5'b01000, 1'b0, 1'b0);
    vecs[10] = jv(16'h0000, 16'h0010, 5'b00010, 5'b11000, 1'b0, 1'b0);
    vecs[11] = kv(1'b0, 1'b1, 8'h6B, 5'b00000, 5'b11000, 1'b0, 1'b0);
    vecs[12] = kv(1'b0, 1'b0, 8'h1D, 5'b00000, 5'b10000, 1'b0, 1'b0);
    vecs[13] = jv(16'h0000, 16'h0000, 5'b00000, 5'b00000, 1'b0, 1'b0);
    vecs[14] = kv(1'b1, 1'b0, 8'h16, 5'b00000, 5'b00000, 1'b1, 1'b0);
    vecs[15] = kv(1'b1, 1'b0, 8'h05, 5'b00000, 5'b00000, 1'b1, 1'b0);
    vecs[16] = kv(1'b0, 1'b0, 8'h16, 5'b00000, 5'b00000, 1'b1, 1'b0);
    vecs[17] = kv(1'b0, 1'b0, 8'h05, 5'b00000, 5'b00000, 1'b0, 1'b0);
    vecs[18] = kv(1'b1, 1'b0, 8'h1E, 5'b00000, 5'b00000, 1'b0, 1'b1);
    vecs[19] = kv(1'b0, 1'b0, 8'h1E, 5'b00000, 5'b00000, 1'b0, 1'b0);
    vecs[20] = jv(16'h0040, 16'h0000, 5'b00000, 5'b00000, 1'b0, 1'b1);
    vecs[21] = jv(16'h0000, 16'h0000, 5'b00000, 5'b00000, 1'b0, 1'b0);

    // Reset
    reset = 1'b1; ps2_key = 11'h0; joystick_0 = 16'h0; joystick_1 = 16'h0;
    auto_coin = 1'b0; tgl = 1'b0;
    tick(); tick(); tick();
    check("reset_outputs", {19'd0, p1, p2, start1, start2, coin1}, 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven vectors
    prev_exp = 12'd0;
    for (int i = 0; i < NV; i++) begin
      new_exp = {vecs[i].ep1, vecs[i].ep2, vecs[i].es1, vecs[i].es2};
      if (vecs[i].is_key) begin
        tgl = ~tgl;
        ps2_key = {tgl, vecs[i].pressed, vecs[i].ext, vecs[i].code};
        tick();
        check($sformatf("vec%0d_lat1", i), {20'd0, p1, p2, start1, start2}, {20'd0, prev_exp});
        tick();
        check($sformatf("vec%0d_lat2", i), {20'd0, p1, p2, start1, start2}, {20'd0, new_exp});
      end else begin
        joystick_0 = vecs[i].joy0;
        joystick_1 = vecs[i].joy1;
        tick();
        check($sformatf("vec%0d_joy", i), {20'd0, p1, p2, start1, start2}, {20'd0, new_exp});
        tick();
      end
      $display("vec %0d: p1=%b p2=%b s1=%b s2=%b", i, p1, p2, start1, start2);
      prev_exp = new_exp;
    end
    check("table_no_coin", {31'd0, coin1}, 32'd0);

    // Coin held 20 cycles: one 8-cycle pulse
    joystick_0 = 16'h0080; highs = 0; rises = 0; prev_c = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 20) joystick_0 = 16'h0;
      tick();
      if (coin1) highs++;
      if (coin1 && !prev_c) rises++;
      prev_c = coin1;
    end
    check("coin_hold_width", highs, 8);
    check("coin_hold_rises", rises, 1);
    $display("coin hold: highs=%0d rises=%0d", highs, rises);

    // Second rise during LOCK is discarded
    joystick_0 = 16'h0080; tick(); tick(); joystick_0 = 16'h0;
    n = 0;
    while (!coin1 && n < 20) begin tick(); n++; end
    check("lock_wait_hi", {31'd0, coin1}, 32'd1);
    n = 0;
    while (coin1 && n < 20) begin tick(); n++; end
    check("lock_wait_lo", {31'd0, coin1}, 32'd0);
    tick();
    joystick_0 = 16'h0080; tick(); joystick_0 = 16'h0;
    highs = 0;
    for (int c = 0; c < 15; c++) begin tick(); if (coin1) highs++; end
    check("lock_discard", highs, 0);
    $display("lock rise: highs=%0d", highs);

    // Rise after LOCK ends: fresh pulse
    joystick_0 = 16'h0080; highs = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) joystick_0 = 16'h0;
      tick();
      if (coin1) highs++;
    end
    check("coin_after_lock", highs, 8);
    $display("post-lock coin: highs=%0d", highs);

    // auto_coin with start from joystick 1
    auto_coin = 1'b1; joystick_1 = 16'h0020; highs = 0;
    tick();
    check("auto_start1", {31'd0, start1}, 32'd1);
    if (coin1) highs++;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) joystick_1 = 16'h0;
      tick();
      if (coin1) highs++;
    end
    check("auto_coin_width", highs, 8);
    check("auto_start1_off", {31'd0, start1}, 32'd0);
    $display("auto_coin=1: highs=%0d", highs);

    auto_coin = 1'b0; joystick_1 = 16'h0020; highs = 0;
    tick();
    check("noauto_start1", {31'd0, start1}, 32'd1);
    if (coin1) highs++;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) joystick_1 = 16'h0;
      tick();
      if (coin1) highs++;
    end
    check("noauto_no_coin", highs, 0);
    $display("auto_coin=0: highs=%0d", highs);

    // Reset in the middle of a pulse
    tgl = 1'b0; ps2_key = 11'h000; tick(); tick();
    joystick_0 = 16'h0080; tick(); joystick_0 = 16'h0;
    n = 0;
    while (!coin1 && n < 20) begin tick(); n++; end
    check("rst_wait_hi", {31'd0, coin1}, 32'd1);
    tick(); tick();
    reset = 1'b1; ps2_key = {1'b1, 1'b1, 1'b1, 8'h74};
    joystick_0 = 16'h0080; joystick_1 = 16'h0010;
    tick();
    check("rst_mid_pulse", {19'd0, p1, p2, start1, start2, coin1}, 32'd0);
    tick();
    joystick_1 = 16'h0;
    reset = 1'b0;
    highs = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (coin1) highs++; end
    check("rst_no_coin", highs, 0);
    check("rst_no_key", {27'd0, p1}, 32'd0);
    $display("post-reset: highs=%0d p1=%b", highs, p1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 SHALL have parameter COIN_PULSE_CYC, default 2400000: coin1 high time in clk_sys cycles; legal range 1 to 2^24-1.
REQ-002 SHALL have parameter COIN_LOCK_CYC, default 2400000: coin1 low lockout after each pulse, in cycles; legal range 1 to 2^24-1.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ps2_key, input, 11 bits: [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scancode.
REQ-006 SHALL have port joystick_0, input, 16 bits: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin.
REQ-007 SHALL have port joystick_1, input, 16 bits, with the same bit map as joystick_0.
REQ-008 SHALL have port auto_coin, input, 1 bit: when 1, a start rising edge also requests a coin.
REQ-009 SHALL have port p1, output, 5 bits: {fire,up,down,left,right} for player 1.
REQ-010 SHALL have port p2, output, 5 bits, with the same bit order as p1, for player 2.
REQ-011 SHALL have ports start1 and start2, outputs, 1 bit each: start levels.
REQ-012 SHALL have port coin1, output, 1 bit: shaped coin pulse.

Function
REQ-013 A key event SHALL be detected when ps2_key[10] differs from its value registered on the previous cycle.
REQ-014 On a detected event, the matching key-state bit SHALL be loaded with ps2_key[9]; events with unmapped codes SHALL be ignored.
REQ-015 The key map SHALL be:
- P1: E0+75 up, E0+72 down, E0+6B left, E0+74 right, 029 fire, 014 fire (E0 don't-care).
- P2: 1D up, 1B down, 1C left, 23 right, 012 fire.
- Start and coin: 016 or 005 start1, 01E or 006 start2, 02E or 036 coin.
REQ-016 Two keys mapped to the same function SHALL each have their own state bit, and the function SHALL be their OR, so releasing one key leaves the function held by the other.
REQ-017 p1 SHALL be the P1 key state OR joystick_0[4:0] (bit order per REQ-009), and p2 SHALL be the P2 key state OR joystick_1[4:0].
REQ-018 start1 SHALL be the start1 key state OR joystick_0[5] OR joystick_1[5], and start2 the start2 key state OR joystick_0[6] OR joystick_1[6].
REQ-019 Outputs p1, p2, start1 and start2 SHALL be registered: 1-cycle latency from the joystick inputs, 2-cycle latency from a ps2_key toggle.
REQ-020 coin_raw SHALL be the coin key state OR joystick_0[7] OR joystick_1[7], OR (auto_coin AND (start1 OR start2)).
REQ-021 A coin request SHALL be a rising edge of registered coin_raw; a level held high SHALL produce exactly one request.
REQ-022 Coin FSM states and transitions SHALL be:
- IDLE: on a request, go to PULSE and load the counter with COIN_PULSE_CYC-1.
- PULSE: coin1=1; when the counter reaches 0, go to LOCK and load COIN_LOCK_CYC-1.
- LOCK: coin1=0; when the counter reaches 0, go to IDLE.
REQ-023 The counter SHALL decrement by 1 each cycle in PULSE and LOCK, and SHALL be 24 bits wide.
REQ-024 coin1 SHALL be a registered FSM output, rising 1 cycle after the edge is registered.
REQ-025 Requests arriving in PULSE or LOCK SHALL be discarded, not queued.
REQ-026 A request arriving in the same cycle as the LOCK-to-IDLE transition SHALL be discarded; coin_raw must rise again to request another coin.

Reset
REQ-027 While reset=1, the module SHALL clear all key-state bits, clear p1, p2, start1, start2 and coin1 to 0, set the FSM to IDLE and the counter to 0.
REQ-028 While reset=1, the toggle register SHALL load ps2_key[10] and the coin_raw register SHALL load coin_raw, so no event or edge fires on the first cycle after reset.
REQ-029 Reset asserted mid-PULSE SHALL drop coin1 on the next clock edge; no pulse SHALL resume after reset.

Structure
REQ-030 Package arcade_input_pkg SHALL hold:
- the scancode constants;
- the joystick bit-index constants;
- enum coin_state_t {IDLE, PULSE, LOCK}.
REQ-031 The coin FSM and counter SHALL be a sub-module coin_pulser (inputs req_edge; output pulse; parameters COIN_PULSE_CYC and COIN_LOCK_CYC).

Verification (bench parameters COIN_PULSE_CYC=8, COIN_LOCK_CYC=4)
REQ-032 The bench SHALL cover:
- Toggle ps2_key with {1,1,0x74}: p1[0]=1 exactly 2 cycles later. Toggle with {0,1,0x74}: p1[0]=0 2 cycles later. Code 0x74 without E0: no change.
- Hold keys 029 and 014; release 029: p1[4] stays 1. Release 014: p1[4]=0.
- joystick_0[7] high for 20 cycles: coin1 high for exactly 8 cycles, then low; a second rise 2 cycles into LOCK gives no pulse; a rise after LOCK ends gives a new 8-cycle pulse.
- auto_coin=1, joystick_1[5] rises: start1=1 after 1 cycle and one 8-cycle coin1 pulse. auto_coin=0: start1 only, coin1 stays 0.
- Assert reset at PULSE cycle 3: coin1=0 next cycle and all outputs 0. Deassert reset with ps2_key[10]=1 and joystick_0[7]=1 held: no key event and no coin pulse.
